// File: rtl/button_event_detect.sv
// button_event_detect: multi-channel push-button conditioner.
// Each channel is a 2-flop synchroniser, a counter-based debounce filter and
// a RELEASED/PRESSED/HELD FSM producing one-cycle press, release, long-press
// and (optionally) auto-repeat pulses.
// Optional feature macro: BUTTON_EVENT_REPEAT_EN (auto-repeat while held).
module button_event_detect #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] button_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_press
);

  localparam int DB_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`endif

  // Raw level that means "not pressed"; also the synchroniser reset value.
  localparam logic IDLE_RAW = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } state_t;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic              meta_p0;
    logic              sync_p1;
    logic              s;
    logic              level;
    logic [DB_W-1:0]   db_cnt;
    logic              accept;
    logic [HOLD_W-1:0] hold_cnt;
    state_t            state;
    logic              press_r;
    logic              release_r;
    logic              long_r;

    // Logical (active-high) view of the synchronised input.
    assign s      = sync_p1 ^ IDLE_RAW;
    // Debounce accepts the new level on this edge.
    assign accept = (s != level) && (db_cnt == DB_LAST);

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
        meta_p0 <= IDLE_RAW;
        sync_p1 <= IDLE_RAW;
      end else begin
        meta_p0 <= button_in[ch];
        sync_p1 <= meta_p0;
      end
    end

    // Debounce: count consecutive cycles of disagreement, accept on the last one.
    always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
        db_cnt <= '0;
        level  <= 1'b0;
      end else if (s == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    // Event FSM; a release on the same edge wins over a due long/repeat pulse.
    always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
        state     <= RELEASED;
        hold_cnt  <= '0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        case (state)
          RELEASED: begin
            hold_cnt <= '0;
            if (accept && s) begin
              state   <= PRESSED;
              press_r <= 1'b1;
            end
          end
          PRESSED: begin
            if (accept && !s) begin
              state     <= RELEASED;
              release_r <= 1'b1;
              hold_cnt  <= '0;
            end else if (hold_cnt == LONG_LAST) begin
              state    <= HELD;
              long_r   <= 1'b1;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          HELD: begin
            if (accept && !s) begin
              state     <= RELEASED;
              release_r <= 1'b1;
              hold_cnt  <= '0;
            end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
              if (hold_cnt == REP_LAST) begin
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
`else
              hold_cnt <= '0;
`endif
            end
          end
          default: begin
            state    <= RELEASED;
            hold_cnt <= '0;
          end
        endcase
      end
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    logic repeat_r;

    // Auto-repeat pulse on each wrap of the HELD period counter, unless releasing.
    always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
        repeat_r <= 1'b0;
      end else begin
        repeat_r <= (state == HELD) && (hold_cnt == REP_LAST) && !(accept && !s);
      end
    end

    assign repeat_pulse[ch] = repeat_r;
`else
    assign repeat_pulse[ch] = 1'b0;
`endif

    assign button_level[ch]  = level;
    assign press_pulse[ch]   = press_r;
    assign release_pulse[ch] = release_r;
    assign long_pulse[ch]    = long_r;
  end

  assign any_press = |press_pulse;

endmodule

// File: tb/tb_button_event_detect.sv
// Bench for button_event_detect: N_CH=2, DEBOUNCE=4, LONG=16, REPEAT=8.
// A second instance with ACTIVE_LOW=1 covers the inverted-input case.
// Expected pulse events are queued with their edge index when stimulus is
// planned and popped as the loop reaches that edge.
module tb_button_event_detect;

  localparam int N_CH = 2;
  localparam int DB   = 4;
  localparam int LC   = 16;
  localparam int RC   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] raw = 2'b00;
  logic [1:0] raw_al = 2'b11;

  logic [1:0] lvl, prs, rel, lng, rep;
  logic       anyp;
  logic [1:0] lvl_al, prs_al, rel_al, lng_al, rep_al;
  logic       anyp_al;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         t;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] l;
    logic [1:0] rp;
  } ev_t;

  ev_t sb[$];

  button_event_detect #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC),
    .REPEAT_CYCLES(RC), .ACTIVE_LOW(0)
  ) dut (
    .clk_sys(clk), .rst(rst), .button_in(raw),
    .button_level(lvl), .press_pulse(prs), .release_pulse(rel),
    .long_pulse(lng), .repeat_pulse(rep), .any_press(anyp)
  );

  button_event_detect #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC),
    .REPEAT_CYCLES(RC), .ACTIVE_LOW(1)
  ) dut_al (
    .clk_sys(clk), .rst(rst), .button_in(raw_al),
    .button_level(lvl_al), .press_pulse(prs_al), .release_pulse(rel_al),
    .long_pulse(lng_al), .repeat_pulse(rep_al), .any_press(anyp_al)
  );

  always #5 clk = ~clk;

  task automatic push_ev(input int t, input logic [1:0] p, input logic [1:0] r,
                         input logic [1:0] l, input logic [1:0] rp);
    ev_t e;
    e.t = t; e.p = p; e.r = r; e.l = l; e.rp = rp;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({lvl, prs, rel, lng, rep, anyp} !== 11'b0) begin
      errors++;
      $display("FAIL reset_main got=%b exp=0", {lvl, prs, rel, lng, rep, anyp});
    end
    checks++;
    if ({lvl_al, prs_al, rel_al, lng_al, rep_al, anyp_al} !== 11'b0) begin
      errors++;
      $display("FAIL reset_active_low got=%b exp=0", {lvl_al, prs_al, rel_al, lng_al, rep_al, anyp_al});
    end
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic test_glitch();
    ev_t e;
    logic [8:0] exp;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      raw[0] = (t < 3);
      @(posedge clk);
      #1;
      exp = '0;
      if (sb.size() != 0 && sb[0].t == t) begin
        e = sb.pop_front();
        exp = {e.p, e.r, e.l, e.rp, |e.p};
      end
      checks++;
      if ({prs, rel, lng, rep, anyp} !== exp) begin
        errors++;
        $display("FAIL glitch_events t=%0d got=%b exp=%b", t, {prs, rel, lng, rep, anyp}, exp);
      end
      checks++;
      if (lvl !== 2'b00) begin
        errors++;
        $display("FAIL glitch_level t=%0d got=%b exp=00", t, lvl);
      end
    end
    raw[0] = 1'b0;
  endtask

  task automatic test_press_release();
    ev_t e;
    logic [8:0] exp;
    push_ev(5,  2'b01, 2'b00, 2'b00, 2'b00);
    push_ev(17, 2'b00, 2'b01, 2'b00, 2'b00);
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      raw[0] = (t < 12);
      @(posedge clk);
      #1;
      exp = '0;
      if (sb.size() != 0 && sb[0].t == t) begin
        e = sb.pop_front();
        exp = {e.p, e.r, e.l, e.rp, |e.p};
      end
      checks++;
      if ({prs, rel, lng, rep, anyp} !== exp) begin
        errors++;
        $display("FAIL press_release_events t=%0d got=%b exp=%b", t, {prs, rel, lng, rep, anyp}, exp);
      end
      if (t == 4 || t == 5 || t == 16 || t == 17) begin
        checks++;
        if (lvl[0] !== (t == 5 || t == 16)) begin
          errors++;
          $display("FAIL press_release_level t=%0d got=%b exp=%b", t, lvl[0], (t == 5 || t == 16));
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL press_release_missing got=%0d pending exp=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_long_press();
    ev_t e;
    logic [8:0] exp;
    push_ev(5,  2'b10, 2'b00, 2'b00, 2'b00);
    push_ev(21, 2'b00, 2'b00, 2'b10, 2'b00);
`ifdef BUTTON_EVENT_REPEAT_EN
    push_ev(29, 2'b00, 2'b00, 2'b00, 2'b10);
    push_ev(37, 2'b00, 2'b00, 2'b00, 2'b10);
`endif
    // Release lands on the edge where a repeat would also be due; release wins.
    push_ev(45, 2'b00, 2'b10, 2'b00, 2'b00);
    for (int t = 0; t < 55; t++) begin
      @(negedge clk);
      raw[1] = (t < 40);
      @(posedge clk);
      #1;
      exp = '0;
      if (sb.size() != 0 && sb[0].t == t) begin
        e = sb.pop_front();
        exp = {e.p, e.r, e.l, e.rp, |e.p};
      end
      checks++;
      if ({prs, rel, lng, rep, anyp} !== exp) begin
        errors++;
        $display("FAIL long_press_events t=%0d got=%b exp=%b", t, {prs, rel, lng, rep, anyp}, exp);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL long_press_missing got=%0d pending exp=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_repeat();
    ev_t e;
    logic [8:0] exp;
    push_ev(5,  2'b01, 2'b00, 2'b00, 2'b00);
    push_ev(21, 2'b00, 2'b00, 2'b01, 2'b00);
`ifdef BUTTON_EVENT_REPEAT_EN
    push_ev(29, 2'b00, 2'b00, 2'b00, 2'b01);
    push_ev(37, 2'b00, 2'b00, 2'b00, 2'b01);
    push_ev(45, 2'b00, 2'b00, 2'b00, 2'b01);
    push_ev(53, 2'b00, 2'b00, 2'b00, 2'b01);
    push_ev(61, 2'b00, 2'b00, 2'b00, 2'b01);
`endif
    push_ev(65, 2'b00, 2'b01, 2'b00, 2'b00);
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      raw[0] = (t < 60);
      @(posedge clk);
      #1;
      exp = '0;
      if (sb.size() != 0 && sb[0].t == t) begin
        e = sb.pop_front();
        exp = {e.p, e.r, e.l, e.rp, |e.p};
      end
      checks++;
      if ({prs, rel, lng, rep, anyp} !== exp) begin
        errors++;
        $display("FAIL repeat_events t=%0d got=%b exp=%b", t, {prs, rel, lng, rep, anyp}, exp);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL repeat_missing got=%0d pending exp=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_simultaneous_active_low();
    ev_t e;
    logic [8:0] exp;
    push_ev(15, 2'b11, 2'b00, 2'b00, 2'b00);
    push_ev(25, 2'b00, 2'b11, 2'b00, 2'b00);
    for (int t = 0; t < 35; t++) begin
      @(negedge clk);
      raw_al = (t >= 10 && t < 20) ? 2'b00 : 2'b11;
      @(posedge clk);
      #1;
      exp = '0;
      if (sb.size() != 0 && sb[0].t == t) begin
        e = sb.pop_front();
        exp = {e.p, e.r, e.l, e.rp, |e.p};
      end
      checks++;
      if ({prs_al, rel_al, lng_al, rep_al, anyp_al} !== exp) begin
        errors++;
        $display("FAIL simul_al_events t=%0d got=%b exp=%b", t, {prs_al, rel_al, lng_al, rep_al, anyp_al}, exp);
      end
      if (t == 15) begin
        checks++;
        if (lvl_al !== 2'b11) begin
          errors++;
          $display("FAIL simul_al_level t=%0d got=%b exp=11", t, lvl_al);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL simul_al_missing got=%0d pending exp=0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_hold();
    ev_t e;
    logic [8:0] exp;
    push_ev(5,  2'b01, 2'b00, 2'b00, 2'b00);
    push_ev(21, 2'b00, 2'b00, 2'b01, 2'b00);
    for (int t = 0; t < 22; t++) begin
      @(negedge clk);
      raw[0] = 1'b1;
      @(posedge clk);
      #1;
      exp = '0;
      if (sb.size() != 0 && sb[0].t == t) begin
        e = sb.pop_front();
        exp = {e.p, e.r, e.l, e.rp, |e.p};
      end
      checks++;
      if ({prs, rel, lng, rep, anyp} !== exp) begin
        errors++;
        $display("FAIL mid_hold_events t=%0d got=%b exp=%b", t, {prs, rel, lng, rep, anyp}, exp);
      end
    end
    // long_pulse is high here; an asynchronous reset must clear it before the next edge.
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({lvl, prs, rel, lng, rep, anyp} !== 11'b0) begin
      errors++;
      $display("FAIL mid_hold_async_clear got=%b exp=0", {lvl, prs, rel, lng, rep, anyp});
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    sb.delete();
    push_ev(5,  2'b01, 2'b00, 2'b00, 2'b00);
    push_ev(15, 2'b00, 2'b01, 2'b00, 2'b00);
    for (int t = 0; t < 22; t++) begin
      @(negedge clk);
      raw[0] = (t < 10);
      @(posedge clk);
      #1;
      exp = '0;
      if (sb.size() != 0 && sb[0].t == t) begin
        e = sb.pop_front();
        exp = {e.p, e.r, e.l, e.rp, |e.p};
      end
      checks++;
      if ({prs, rel, lng, rep, anyp} !== exp) begin
        errors++;
        $display("FAIL after_reset_events t=%0d got=%b exp=%b", t, {prs, rel, lng, rep, anyp}, exp);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL after_reset_missing got=%0d pending exp=0", sb.size());
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_release();
    test_long_press();
    test_repeat();
    test_simultaneous_active_low();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
